// File: rtl/pcs_sync_multilane.sv
// N-lane 1000BASE-X PCS code-group synchroniser, one independent sync FSM per lane.
// Optional loss-of-sync statistics (los_count port) are enabled by defining SYNC_STATS_EN.
module pcs_sync_multilane #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned ACQ_COMMAS = 3,
    parameter int unsigned MAX_BAD    = 4,
    parameter int unsigned GOOD_CGS   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    PUDI,
    input  logic [10*LANES-1:0] rx_code_group,
    output logic [10*LANES-1:0] x,
    output logic [LANES-1:0]    SUDI,
    output logic [LANES-1:0]    rx_even,
    output logic [LANES-1:0]    sync_status
`ifdef SYNC_STATS_EN
    ,
    output logic [8*LANES-1:0]  los_count
`endif
);

    typedef enum logic [1:0] {
        StLossOfSync   = 2'd0,
        StAcquire      = 2'd1,
        StSyncAcquired = 2'd2
    } state_e;

    localparam logic [2:0] AcqLimit  = 3'(ACQ_COMMAS);
    localparam logic [2:0] BadLimit  = 3'(MAX_BAD);
    localparam logic [2:0] GoodLimit = 3'(GOOD_CGS);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        state_e     state_q, state_d;
        logic [2:0] acq_cnt_q, acq_cnt_d;
        logic [2:0] bad_cnt_q, bad_cnt_d;
        logic [2:0] good_cnt_q, good_cnt_d;
        logic [9:0] x_q, x_d;
        logic       sudi_q, sudi_d;
        logic       even_q, even_d;
        logic [9:0] cg;
        logic       comma, valid, bad, even_nx;

        assign cg    = rx_code_group[10*k +: 10];
        assign comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
        assign valid = ($countones(cg) >= 4) && ($countones(cg) <= 6) &&
                       (cg[9:4] != 6'b111111) && (cg[9:4] != 6'b000000);
        // A comma seen while out of sync re-establishes even alignment.
        assign even_nx = ((state_q == StLossOfSync) && comma) ? 1'b1 : ~even_q;
        assign bad     = !valid || (comma && !even_nx);

        always_comb begin
            state_d    = state_q;
            acq_cnt_d  = acq_cnt_q;
            bad_cnt_d  = bad_cnt_q;
            good_cnt_d = good_cnt_q;
            x_d        = x_q;
            even_d     = even_q;
            sudi_d     = 1'b0;
            if (PUDI[k]) begin
                sudi_d = 1'b1;
                x_d    = cg;
                even_d = even_nx;
                unique case (state_q)
                    StLossOfSync: begin
                        if (comma) begin
                            state_d   = StAcquire;
                            acq_cnt_d = 3'd1;
                        end
                    end
                    StAcquire: begin
                        if (bad) begin
                            state_d   = StLossOfSync;
                            acq_cnt_d = 3'd0;
                        end else if (comma) begin
                            if (acq_cnt_q + 3'd1 == AcqLimit) begin
                                state_d    = StSyncAcquired;
                                acq_cnt_d  = 3'd0;
                                bad_cnt_d  = 3'd0;
                                good_cnt_d = 3'd0;
                            end else begin
                                acq_cnt_d = acq_cnt_q + 3'd1;
                            end
                        end
                    end
                    StSyncAcquired: begin
                        if (bad) begin
                            good_cnt_d = 3'd0;
                            if (bad_cnt_q + 3'd1 == BadLimit) begin
                                state_d   = StLossOfSync;
                                bad_cnt_d = 3'd0;
                            end else begin
                                bad_cnt_d = bad_cnt_q + 3'd1;
                            end
                        end else if (bad_cnt_q != 3'd0) begin
                            // Every GOOD_CGS clean code groups repay one bad credit.
                            if (good_cnt_q + 3'd1 == GoodLimit) begin
                                bad_cnt_d  = bad_cnt_q - 3'd1;
                                good_cnt_d = 3'd0;
                            end else begin
                                good_cnt_d = good_cnt_q + 3'd1;
                            end
                        end else begin
                            good_cnt_d = 3'd0;
                        end
                    end
                    default: state_d = StLossOfSync;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q    <= StLossOfSync;
                acq_cnt_q  <= 3'd0;
                bad_cnt_q  <= 3'd0;
                good_cnt_q <= 3'd0;
                x_q        <= 10'd0;
                sudi_q     <= 1'b0;
                even_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                acq_cnt_q  <= acq_cnt_d;
                bad_cnt_q  <= bad_cnt_d;
                good_cnt_q <= good_cnt_d;
                x_q        <= x_d;
                sudi_q     <= sudi_d;
                even_q     <= even_d;
            end
        end

        assign x[10*k +: 10]  = x_q;
        assign SUDI[k]        = sudi_q;
        assign rx_even[k]     = even_q;
        assign sync_status[k] = (state_q == StSyncAcquired);

`ifdef SYNC_STATS_EN
        logic [7:0] los_q, los_d;

        always_comb begin
            los_d = los_q;
            if (PUDI[k] && (state_q == StSyncAcquired) && (state_d == StLossOfSync) &&
                (los_q != 8'hFF)) begin
                los_d = los_q + 8'd1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) los_q <= 8'd0;
            else      los_q <= los_d;
        end

        assign los_count[8*k +: 8] = los_q;
`endif
    end

endmodule

// File: tb/tb_pcs_sync_multilane.sv
// Scoreboard bench for pcs_sync_multilane (4 lanes): directed scenarios plus randomized streams.
// Honours SYNC_STATS_EN to exercise the loss-of-sync counters.
module tb_pcs_sync_multilane;

    localparam int LANES      = 4;
    localparam int ACQ_COMMAS = 3;
    localparam int MAX_BAD    = 4;
    localparam int GOOD_CGS   = 3;
`ifdef SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [9:0] KM   = 10'b0011111010;  // K28.5-
    localparam logic [9:0] KP   = 10'b1100000101;  // K28.5+
    localparam logic [9:0] DD   = 10'b0110110101;  // D16.2
    localparam logic [9:0] ONES = 10'h3FF;
    localparam logic [9:0] ZERO = 10'h000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [LANES-1:0]    PUDI = '0;
    logic [10*LANES-1:0] rx_code_group = '0;
    logic [10*LANES-1:0] x;
    logic [LANES-1:0]    SUDI, rx_even, sync_status;
    logic [8*LANES-1:0]  los_count;

    pcs_sync_multilane #(
        .LANES     (LANES),
        .ACQ_COMMAS(ACQ_COMMAS),
        .MAX_BAD   (MAX_BAD),
        .GOOD_CGS  (GOOD_CGS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PUDI         (PUDI),
        .rx_code_group(rx_code_group),
        .x            (x),
        .SUDI         (SUDI),
        .rx_even      (rx_even),
        .sync_status  (sync_status)
`ifdef SYNC_STATS_EN
        ,
        .los_count    (los_count)
`endif
    );
`ifndef SYNC_STATS_EN
    assign los_count = '0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lane;
        logic [9:0] x;
        logic       even;
        logic       sync;
        logic [7:0] los;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-lane variables named after the spec's quantities.
    bit in_sync[LANES];
    bit acquiring[LANES];
    int commas_seen[LANES];
    int credits_used[LANES];
    int good_run[LANES];
    bit parity_even[LANES];
    int losses[LANES];

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            in_sync[k] = 0; acquiring[k] = 0; commas_seen[k] = 0;
            credits_used[k] = 0; good_run[k] = 0; parity_even[k] = 0; losses[k] = 0;
        end
        sb.delete();
    endtask

    task automatic model_step(input int k, input logic [9:0] cg);
        int   ones;
        bit   is_comma, is_valid, is_bad;
        exp_t e;
        ones = 0;
        for (int b = 0; b < 10; b++) ones += int'(cg[b]);
        is_comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
        is_valid = (ones >= 4 && ones <= 6) && cg[9:4] != 6'h3F && cg[9:4] != 6'h00;
        if (!in_sync[k] && !acquiring[k] && is_comma) parity_even[k] = 1;
        else parity_even[k] = !parity_even[k];
        is_bad = !is_valid || (is_comma && !parity_even[k]);
        if (in_sync[k]) begin
            if (is_bad) begin
                credits_used[k]++;
                good_run[k] = 0;
                if (credits_used[k] >= MAX_BAD) begin
                    in_sync[k] = 0;
                    if (STATS && losses[k] < 255) losses[k]++;
                end
            end else if (credits_used[k] > 0) begin
                good_run[k]++;
                if (good_run[k] >= GOOD_CGS) begin
                    credits_used[k]--;
                    good_run[k] = 0;
                end
            end
        end else if (acquiring[k]) begin
            if (is_bad) begin
                acquiring[k] = 0;
            end else if (is_comma) begin
                commas_seen[k]++;
                if (commas_seen[k] >= ACQ_COMMAS) begin
                    acquiring[k] = 0; in_sync[k] = 1; credits_used[k] = 0; good_run[k] = 0;
                end
            end
        end else if (is_comma) begin
            acquiring[k] = 1;
            commas_seen[k] = 1;
        end
        e.lane = 2'(k);
        e.x    = cg;
        e.even = parity_even[k];
        e.sync = in_sync[k];
        e.los  = 8'(losses[k]);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [LANES-1:0] p, input logic [9:0] c0, input logic [9:0] c1,
                         input logic [9:0] c2, input logic [9:0] c3);
        logic [9:0] cg[LANES];
        cg = '{c0, c1, c2, c3};
        @(posedge clk); #1;
        PUDI = p;
        rx_code_group = {c3, c2, c1, c0};
        for (int k = 0; k < LANES; k++) if (p[k]) model_step(k, cg[k]);
    endtask

    task automatic settle();
        @(posedge clk); #1;
        PUDI = '0;
    endtask

    task automatic check_eq(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_x"}, 40'(x), 40'd0);
        check_eq({tag, "_sudi"}, 40'(SUDI), 40'd0);
        check_eq({tag, "_rx_even"}, 40'(rx_even), 40'd0);
        check_eq({tag, "_sync"}, 40'(sync_status), 40'd0);
        check_eq({tag, "_los"}, 40'(los_count), 40'd0);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk); #3;
        rst  = 1'b0;
        PUDI = '0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    // Monitor: one scoreboard entry per SUDI strobe, lanes popped in ascending order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < LANES; k++) begin
                    if (SUDI[k]) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL sudi_unexpected lane %0d x=%0h at %0t", k, x[10*k +: 10], $time);
                        end else begin
                            e = sb.pop_front();
                            if (e.lane != 2'(k) || x[10*k +: 10] !== e.x || rx_even[k] !== e.even ||
                                sync_status[k] !== e.sync || los_count[8*k +: 8] !== e.los) begin
                                errors++;
                                $display("FAIL sudi_lane%0d: got x=%0h even=%0b sync=%0b los=%0d expected lane%0d x=%0h even=%0b sync=%0b los=%0d at %0t",
                                         k, x[10*k +: 10], rx_even[k], sync_status[k], los_count[8*k +: 8],
                                         e.lane, e.x, e.even, e.sync, e.los, $time);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] rc[LANES];
        logic [LANES-1:0] rp;
        model_reset();
        #2;
        check_all_zero("reset");
        #10;
        rst = 1'b1;

        // Three even-aligned commas on lanes 0/1/3; lane 2 sees only invalid code groups.
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, KM, KM, ONES, KM);
            drive(4'hF, DD, DD, ZERO, DD);
        end
        settle();
        check_eq("acquire_sync", 40'(sync_status), 40'(4'b1011));

        // PUDI gaps on lane 1 hold its state.
        for (int i = 0; i < 5; i++) drive(4'b1101, DD, KM, ONES, DD);
        settle();
        check_eq("gap_hold_sync", 40'(sync_status), 40'(4'b1011));
        drive(4'b1111, DD, DD, ZERO, DD);

        // Four consecutive invalid groups on lane 0 drop sync on the fourth.
        for (int i = 0; i < 4; i++) drive(4'b0001, ONES, DD, DD, DD);
        settle();
        check_eq("loss_after_4_bad", 40'(sync_status), 40'(4'b1010));
        check_eq("los_count_one", 40'(los_count[7:0]), STATS ? 40'd1 : 40'd0);

        // Credit repayment: 3 bad, 3 good, 1 bad stays synced; a further bad loses sync.
        for (int i = 0; i < 5; i++) drive(4'b0001, (i % 2 == 0) ? KM : DD, DD, DD, DD);
        for (int i = 0; i < 3; i++) drive(4'b0001, ONES, DD, DD, DD);
        for (int i = 0; i < 3; i++) drive(4'b0001, DD, DD, DD, DD);
        drive(4'b0001, ONES, DD, DD, DD);
        settle();
        check_eq("credit_repaid", 40'(sync_status), 40'(4'b1011));
        drive(4'b0001, ONES, DD, DD, DD);
        settle();
        check_eq("credit_exhausted", 40'(sync_status), 40'(4'b1010));

        // Odd-aligned comma during ACQUIRE aborts; the next comma restarts acquisition.
        drive(4'b0001, KM, DD, DD, DD);
        drive(4'b0001, DD, DD, DD, DD);
        drive(4'b0001, KM, DD, DD, DD);
        drive(4'b0001, KP, DD, DD, DD);
        settle();
        check_eq("odd_comma_abort", 40'(sync_status), 40'(4'b1010));
        for (int i = 0; i < 5; i++) drive(4'b0001, (i % 2 == 0) ? KP : DD, DD, DD, DD);
        settle();
        check_eq("reacquire", 40'(sync_status), 40'(4'b1011));

        // Reset with lane 0 mid-ACQUIRE and lanes 1/3 in sync.
        for (int i = 0; i < 4; i++) drive(4'b0001, ONES, DD, DD, DD);
        drive(4'b0001, KM, DD, DD, DD);
        drive(4'b0001, DD, DD, DD, DD);
        async_reset("mid_reset");

        // Randomized streams on all lanes, with an asynchronous reset halfway through.
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < LANES; k++) begin
                int pick;
                pick = int'($urandom_range(0, 9));
                if (pick < 2)      rc[k] = KM;
                else if (pick < 4) rc[k] = KP;
                else if (pick < 8) rc[k] = DD;
                else if (pick < 9) rc[k] = 10'($urandom);
                else               rc[k] = ONES;
                rp[k] = ($urandom_range(0, 7) != 0);
            end
            drive(rp, rc[0], rc[1], rc[2], rc[3]);
            if (i == 400) async_reset("rand_reset");
        end
        settle();

        // Repeated acquire/lose cycles on lane 0 to saturate the loss counter.
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 5; i++) drive(4'b0001, (i % 2 == 0) ? KM : DD, DD, DD, DD);
            for (int i = 0; i < 4; i++) drive(4'b0001, ONES, DD, DD, DD);
        end
        settle();
        check_eq("los_saturate", 40'(los_count[7:0]), STATS ? 40'hFF : 40'd0);
        check_eq("final_sync_lane0", 40'(sync_status[0]), 40'd0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", 40'(sb.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
